// File: rtl/fd_record_scheduler.sv
// Shares one DRAM bridge port between D and R record requesters behind a one-entry write-back cache.
// Latency: hit/no-op acks 1 cycle after grant; misses add one or two bridge round trips (evict, fill).
// Backpressure: requests hold until their ack pulse; only one bridge command is ever outstanding.

module fd_record_scheduler #(
    parameter int ID_W      = 8,
    parameter int DATA_W    = 64,
    parameter int FIXED_PRI = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              d_req,
    input  logic              d_wr,
    input  logic [ID_W-1:0]   d_id,
    input  logic [1:0]        d_mask,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    input  logic              r_req,
    input  logic              r_wr,
    input  logic [ID_W-1:0]   r_id,
    input  logic [1:0]        r_mask,
    input  logic [DATA_W-1:0] r_wdata,
    output logic              r_ack,
    output logic [DATA_W-1:0] r_rdata,
    input  logic              flush,
    output logic              flush_done,
    output logic              C_in_valid,
    output logic [ID_W-1:0]   C_addr,
    output logic              C_r_wb,
    output logic [DATA_W-1:0] C_data_w,
    input  logic              C_out_valid,
    input  logic [DATA_W-1:0] C_data_r
);

    localparam int HW = DATA_W / 2;

    typedef enum logic [2:0] {S_IDLE, S_WB, S_FILL, S_RESP, S_FDONE} state_t;

    // Overwrite the halves of base selected by mask {hi,lo} with wd.
    function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] base,
                                                input logic [DATA_W-1:0] wd,
                                                input logic [1:0]        m);
        logic [DATA_W-1:0] r;
        r = base;
        if (m[0]) r[HW-1:0]      = wd[HW-1:0];
        if (m[1]) r[DATA_W-1:HW] = wd[DATA_W-1:HW];
        return r;
    endfunction

    state_t            state_q;
    logic              valid_q, dirty_q, rr_q, flush_pend_q, wb_flush_q, gnt_r_q;
    logic [ID_W-1:0]   cid_q, g_id_q;
    logic [DATA_W-1:0] cdata_q, g_wdata_q;
    logic              g_wr_q;
    logic [1:0]        g_mask_q;
    logic              d_ack_q, r_ack_q, flush_done_q, c_in_valid_q, c_r_wb_q;
    logic [DATA_W-1:0] d_rdata_q, r_rdata_q, c_data_w_q;
    logic [ID_W-1:0]   c_addr_q;

    logic              gnt_r_d, n_wr, flush_any, evict, hit, nop_wr, full_wr, resp_r;
    logic [ID_W-1:0]   n_id;
    logic [1:0]        n_mask;
    logic [DATA_W-1:0] n_wdata, fast_dat, fill_dat;

    assign d_ack      = d_ack_q;
    assign r_ack      = r_ack_q;
    assign d_rdata    = d_rdata_q;
    assign r_rdata    = r_rdata_q;
    assign flush_done = flush_done_q;
    assign C_in_valid = c_in_valid_q;
    assign C_addr     = c_addr_q;
    assign C_r_wb     = c_r_wb_q;
    assign C_data_w   = c_data_w_q;

    // Arbitration, hit detection and the record values a response would carry.
    always_comb begin
        gnt_r_d   = r_req && (!d_req || ((FIXED_PRI == 0) && rr_q));
        n_wr      = gnt_r_d ? r_wr    : d_wr;
        n_id      = gnt_r_d ? r_id    : d_id;
        n_mask    = gnt_r_d ? r_mask  : d_mask;
        n_wdata   = gnt_r_d ? r_wdata : d_wdata;
        flush_any = flush || flush_pend_q;
        evict     = valid_q && dirty_q;
        hit       = valid_q && (n_id == cid_q);
        nop_wr    = n_wr && (n_mask == 2'b00);
        full_wr   = n_wr && (n_mask == 2'b11);
        if (nop_wr)
            fast_dat = cdata_q;
        else if (hit)
            fast_dat = n_wr ? merge(cdata_q, n_wdata, n_mask) : cdata_q;
        else
            fast_dat = n_wdata;
        fill_dat  = merge(C_data_r, g_wdata_q, g_wr_q ? g_mask_q : 2'b00);
        resp_r    = (state_q == S_IDLE) ? gnt_r_d : gnt_r_q;
    end

    // Scheduler FSM: cache state, bridge sequencing and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            valid_q      <= 1'b0;
            dirty_q      <= 1'b0;
            rr_q         <= 1'b0;
            flush_pend_q <= 1'b0;
            wb_flush_q   <= 1'b0;
            gnt_r_q      <= 1'b0;
            cid_q        <= '0;
            cdata_q      <= '0;
            g_id_q       <= '0;
            g_wr_q       <= 1'b0;
            g_mask_q     <= 2'b00;
            g_wdata_q    <= '0;
            d_ack_q      <= 1'b0;
            r_ack_q      <= 1'b0;
            d_rdata_q    <= '0;
            r_rdata_q    <= '0;
            flush_done_q <= 1'b0;
            c_in_valid_q <= 1'b0;
            c_addr_q     <= '0;
            c_r_wb_q     <= 1'b0;
            c_data_w_q   <= '0;
        end else begin
            d_ack_q      <= 1'b0;
            r_ack_q      <= 1'b0;
            flush_done_q <= 1'b0;
            c_in_valid_q <= 1'b0;
            if (flush) flush_pend_q <= 1'b1;
            case (state_q)
                S_IDLE: begin
                    if (flush_any) begin
                        if (evict) begin
                            wb_flush_q   <= 1'b1;
                            state_q      <= S_WB;
                            c_in_valid_q <= 1'b1;
                            c_r_wb_q     <= 1'b0;
                            c_addr_q     <= cid_q;
                            c_data_w_q   <= cdata_q;
                        end else begin
                            state_q      <= S_FDONE;
                            flush_done_q <= 1'b1;
                        end
                    end else if (d_req || r_req) begin
                        gnt_r_q   <= gnt_r_d;
                        rr_q      <= !gnt_r_d;
                        g_id_q    <= n_id;
                        g_wr_q    <= n_wr;
                        g_mask_q  <= n_mask;
                        g_wdata_q <= n_wdata;
                        if (nop_wr || hit || (full_wr && !evict)) begin
                            // Served from the cache (or installed outright) with no bridge traffic.
                            state_q <= S_RESP;
                            d_ack_q <= !resp_r;
                            r_ack_q <= resp_r;
                            if (resp_r) r_rdata_q <= fast_dat;
                            else        d_rdata_q <= fast_dat;
                            if (!nop_wr) begin
                                valid_q <= 1'b1;
                                cid_q   <= n_id;
                                cdata_q <= fast_dat;
                                if (n_wr) dirty_q <= 1'b1;
                            end
                        end else if (evict) begin
                            wb_flush_q   <= 1'b0;
                            state_q      <= S_WB;
                            c_in_valid_q <= 1'b1;
                            c_r_wb_q     <= 1'b0;
                            c_addr_q     <= cid_q;
                            c_data_w_q   <= cdata_q;
                        end else begin
                            state_q      <= S_FILL;
                            c_in_valid_q <= 1'b1;
                            c_r_wb_q     <= 1'b1;
                            c_addr_q     <= n_id;
                        end
                    end
                end
                S_WB: begin
                    if (C_out_valid) begin
                        dirty_q <= 1'b0;
                        if (wb_flush_q) begin
                            state_q      <= S_FDONE;
                            flush_done_q <= 1'b1;
                        end else if (g_wr_q && (g_mask_q == 2'b11)) begin
                            // Full-record write needs no fill once the victim is written back.
                            state_q <= S_RESP;
                            valid_q <= 1'b1;
                            dirty_q <= 1'b1;
                            cid_q   <= g_id_q;
                            cdata_q <= g_wdata_q;
                            d_ack_q <= !resp_r;
                            r_ack_q <= resp_r;
                            if (resp_r) r_rdata_q <= g_wdata_q;
                            else        d_rdata_q <= g_wdata_q;
                        end else begin
                            state_q      <= S_FILL;
                            c_in_valid_q <= 1'b1;
                            c_r_wb_q     <= 1'b1;
                            c_addr_q     <= g_id_q;
                        end
                    end
                end
                S_FILL: begin
                    if (C_out_valid) begin
                        state_q <= S_RESP;
                        valid_q <= 1'b1;
                        dirty_q <= g_wr_q;
                        cid_q   <= g_id_q;
                        cdata_q <= fill_dat;
                        d_ack_q <= !resp_r;
                        r_ack_q <= resp_r;
                        if (resp_r) r_rdata_q <= fill_dat;
                        else        d_rdata_q <= fill_dat;
                    end
                end
                S_RESP:  state_q <= S_IDLE;
                S_FDONE: begin
                    // Pulses already merged into this flush are retired; a fresh one starts over.
                    flush_pend_q <= flush;
                    state_q      <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
